// File: rtl/btn_gesture_decoder.sv
// btn_gesture_decoder
// Classifies debounced pushbutton activity (DPB level, SCEN press pulse,
// MCEN repeat pulse) into single click, double click and long press events,
// delivered through a one-entry valid/ready output register.
//
// Event codes: 01 single, 10 double, 11 long, 00 repeat.
// Optional build macro BTN_GESTURE_REPEAT_EN: while a long press is held,
// every MCEN pulse posts a repeat event (code 00). Without the macro the
// LONG state ignores MCEN and code 00 is never produced.
module btn_gesture_decoder #(
    parameter int GAP_W     = 5,
    parameter int LONG_MCEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dpb_i,
    input  logic       scen_i,
    input  logic       mcen_i,
    input  logic       evt_ready,
    input  logic       ovr_clr,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    output logic       evt_overrun,
    output logic       busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PRESS1 = 3'd1;
    localparam logic [2:0] S_GAP    = 3'd2;
    localparam logic [2:0] S_PRESS2 = 3'd3;
    localparam logic [2:0] S_LONG   = 3'd4;

    localparam logic [1:0] C_REPEAT = 2'b00;
    localparam logic [1:0] C_SINGLE = 2'b01;
    localparam logic [1:0] C_DOUBLE = 2'b10;
    localparam logic [1:0] C_LONG   = 2'b11;

    localparam logic [GAP_W-1:0] GAP_LAST = '1;
    localparam logic [3:0]       LONG_CNT = 4'(LONG_MCEN);

    logic [2:0]       state, state_nxt;
    logic [3:0]       mcen_cnt, mcen_cnt_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
    logic             post;
    logic [1:0]       post_code;
    logic             mcen_counted;
    logic [3:0]       mcen_inc;
    logic             drop;

    // The debouncer fires SCEN and MCEN together on the first-press cycle;
    // that MCEN belongs to the press itself and must not count toward "long".
    assign mcen_counted = mcen_i && !scen_i;
    assign mcen_inc     = (mcen_cnt == 4'hF) ? mcen_cnt : mcen_cnt + 4'd1;

    // A post that finds the register full and not being drained is lost.
    assign drop = post && evt_valid && !evt_ready;

    // Gesture classification: next state, counters and event posting.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nxt    = state;
        mcen_cnt_nxt = mcen_cnt;
        gap_cnt_nxt  = gap_cnt;
        post         = 1'b0;
        post_code    = C_SINGLE;
        case (state)
            S_IDLE: begin
                if (scen_i) begin
                    state_nxt    = S_PRESS1;
                    mcen_cnt_nxt = '0;
                end
            end
            S_PRESS1: begin
                if (mcen_counted) begin
                    mcen_cnt_nxt = mcen_inc;
                end
                // Reaching the long threshold beats a release in the same cycle.
                if (mcen_counted && (mcen_inc == LONG_CNT)) begin
                    post      = 1'b1;
                    post_code = C_LONG;
                    state_nxt = S_LONG;
                end else if (!dpb_i) begin
                    state_nxt   = S_GAP;
                    gap_cnt_nxt = '0;
                end
            end
            S_GAP: begin
                gap_cnt_nxt = gap_cnt + 1'b1;
                // A second press on the final window cycle still makes a double.
                if (scen_i) begin
                    state_nxt = S_PRESS2;
                end else if (gap_cnt == GAP_LAST) begin
                    post      = 1'b1;
                    post_code = C_SINGLE;
                    state_nxt = S_IDLE;
                end
            end
            S_PRESS2: begin
                // MCEN is ignored here: a held second press is still a double.
                if (!dpb_i) begin
                    post      = 1'b1;
                    post_code = C_DOUBLE;
                    state_nxt = S_IDLE;
                end
            end
            S_LONG: begin
`ifdef BTN_GESTURE_REPEAT_EN
                if (mcen_i) begin
                    post      = 1'b1;
                    post_code = C_REPEAT;
                end
`endif
                if (!dpb_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and counter registers; busy is registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state    <= S_IDLE;
            mcen_cnt <= '0;
            gap_cnt  <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            mcen_cnt <= mcen_cnt_nxt;
            gap_cnt  <= gap_cnt_nxt;
            busy     <= (state_nxt != S_IDLE);
        end
    end

    // One-entry event register with back-to-back hand-off and sticky overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_valid   <= 1'b0;
            evt_code    <= 2'b00;
            evt_overrun <= 1'b0;
        end else begin
            if (post) begin
                if (!evt_valid || evt_ready) begin
                    evt_valid <= 1'b1;
                    evt_code  <= post_code;
                end
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end

            // A drop outranks a clear requested in the same cycle.
            if (drop) begin
                evt_overrun <= 1'b1;
            end else if (ovr_clr) begin
                evt_overrun <= 1'b0;
            end
        end
    end

endmodule
